// File: rtl/loop_addr_table_multi_if.sv
// Fetch-side bundle between the fetch unit and the loop-address table.
// Signal names match the block's published port names.
interface loop_addr_table_multi_if #(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_W        = 16
);
    logic [FETCH_WIDTH*PC_W-1:0] pc_in;
    logic [FETCH_WIDTH-1:0]      bck_lp_bus_in;
    logic                        fetch_valid_in;
    logic                        mis_pred_in;
    logic                        lat_flush_in;
    logic [1:0]                  lbd_state_out;
    logic                        loop_strt_out;
    logic [FETCH_WIDTH-1:0]      inst_valid_out;
    logic                        fnsh_unrll_out;
    logic                        stll_ftch_out;

    modport master (
        output pc_in, bck_lp_bus_in, fetch_valid_in,
        output mis_pred_in, lat_flush_in,
        input  lbd_state_out, loop_strt_out, inst_valid_out,
        input  fnsh_unrll_out, stll_ftch_out
    );

    modport slave (
        input  pc_in, bck_lp_bus_in, fetch_valid_in,
        input  mis_pred_in, lat_flush_in,
        output lbd_state_out, loop_strt_out, inst_valid_out,
        output fnsh_unrll_out, stll_ftch_out
    );
endinterface

// File: rtl/loop_addr_table_multi.sv
// Loop detection / unroll controller: learns backward-branch loop bodies
// into a small table, then masks and counts re-fetched loop groups.
module loop_addr_table_multi #(
    parameter int FETCH_WIDTH = 4,
    parameter int PC_W        = 16,
    parameter int ENTRIES     = 4,
    parameter int MAX_INSTS   = 64,
    parameter int CNT_W       = 8
) (
    input logic                    clk,
    input logic                    rst,
    loop_addr_table_multi_if.slave bus
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INSTS);
    localparam logic [CNT_W-1:0] FW_C  = CNT_W'(FETCH_WIDTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_TRAIN = 2'b01,
        S_DISP  = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [ENTRIES-1:0] vld_q, vld_d;
    logic [PC_W-1:0]    start_q [ENTRIES];
    logic [PC_W-1:0]    start_d [ENTRIES];
    logic [PC_W-1:0]    tail_q  [ENTRIES];
    logic [PC_W-1:0]    tail_d  [ENTRIES];
    logic [CNT_W-1:0]   num_q   [ENTRIES];
    logic [CNT_W-1:0]   num_d   [ENTRIES];
    logic [IDX_W-1:0]   rr_q, rr_d;

    logic [PC_W-1:0]  lp_tail_q, lp_tail_d;
    logic [PC_W-1:0]  tr_start_q, tr_start_d;
    logic [CNT_W-1:0] lp_num_q, lp_num_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             pend_q, pend_d;
    logic             fnsh_q, fnsh_d;
    logic             stll_q, stll_d;

    logic [PC_W-1:0]        slot_pc [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] slot_bck;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [PC_W-1:0]        bck_pc;
    logic [PC_W-1:0]        cur_tail;
    logic [CNT_W-1:0]       cur_num;
    logic                   tmatch;
    logic [CNT_W-1:0]       tcnt;
    logic [FETCH_WIDTH-1:0] dmask;
    logic [PC_W-1:0]        start_eff;
    logic                   upd;
    logic [IDX_W-1:0]       upd_idx;

    // Slot decode, table lookup and oldest tail match in the current group
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        bck_pc   = '0;
        tmatch   = 1'b0;
        tcnt     = '0;
        dmask    = '1;
        upd      = 1'b0;
        upd_idx  = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            slot_pc[k]  = bus.pc_in[(FETCH_WIDTH-k)*PC_W-1 -: PC_W];
            slot_bck[k] = bus.bck_lp_bus_in[FETCH_WIDTH-1-k];
        end
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (vld_q[e] && start_q[e] == slot_pc[0]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(e);
            end
        end
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            if (slot_bck[k]) bck_pc = slot_pc[k];
        end
        cur_tail = (state_q == S_IDLE) ? tail_q[hit_idx] : lp_tail_q;
        cur_num  = (state_q == S_IDLE) ? num_q[hit_idx] : lp_num_q;
        for (int k = FETCH_WIDTH - 1; k >= 0; k--) begin
            if (slot_pc[k] == cur_tail) begin
                tmatch = 1'b1;
                tcnt   = CNT_W'(k + 1);
            end
        end
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            dmask[FETCH_WIDTH-1-k] = !tmatch || (CNT_W'(k) < tcnt);
        end
        start_eff = pend_q ? slot_pc[0] : tr_start_q;
        for (int e = ENTRIES - 1; e >= 0; e--) begin
            if (vld_q[e] && start_q[e] == start_eff) begin
                upd     = 1'b1;
                upd_idx = IDX_W'(e);
            end
        end
    end

    logic [FETCH_WIDTH-1:0] mask;
    logic                   disp_go;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_idx;
    logic [CNT_W-1:0]       issued_new;
    logic [CNT_W-1:0]       num_new;

    always_comb begin
        state_d    = state_q;
        vld_d      = vld_q;
        start_d    = start_q;
        tail_d     = tail_q;
        num_d      = num_q;
        rr_d       = rr_q;
        lp_tail_d  = lp_tail_q;
        tr_start_d = tr_start_q;
        lp_num_d   = lp_num_q;
        issued_d   = issued_q;
        pend_d     = pend_q;
        fnsh_d     = fnsh_q;
        stll_d     = stll_q;
        mask       = '1;
        disp_go    = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = rr_q;
        issued_new = '0;
        num_new    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.fetch_valid_in) begin
                    if (hit) begin
                        lp_tail_d = tail_q[hit_idx];
                        lp_num_d  = num_q[hit_idx];
                        state_d   = S_DISP;
                        disp_go   = 1'b1;
                    end else if (|slot_bck) begin
                        lp_tail_d = bck_pc;
                        lp_num_d  = '0;
                        pend_d    = 1'b1;
                        state_d   = S_TRAIN;
                    end
                end
            end
            S_TRAIN: begin
                if (bus.fetch_valid_in) begin
                    tr_start_d = start_eff;
                    pend_d     = 1'b0;
                    if (tmatch) begin
                        lp_num_d = lp_num_q + tcnt;
                        wr_en    = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        num_new  = lp_num_q + FW_C;
                        lp_num_d = num_new;
                        if (num_new > MAX_C) state_d = S_IDLE;
                    end
                end
            end
            S_DISP: begin
                mask    = '0;
                disp_go = bus.fetch_valid_in;
            end
            S_HOLD: mask = '0;
        endcase

        // The hit group in IDLE is handled exactly like a DISPATCH group
        if (disp_go) begin
            issued_new = (state_q == S_IDLE) ? '0 : issued_q;
            issued_new = issued_new + (tmatch ? tcnt : FW_C);
            issued_d   = issued_new;
            mask       = dmask;
            if (tmatch && (issued_new + cur_num > MAX_C)) begin
                fnsh_d  = 1'b1;
                stll_d  = 1'b1;
                state_d = S_HOLD;
            end
        end

        if (bus.mis_pred_in || bus.lat_flush_in) begin
            state_d  = S_IDLE;
            issued_d = '0;
            lp_num_d = '0;
            pend_d   = 1'b0;
            fnsh_d   = 1'b0;
            stll_d   = 1'b0;
            wr_en    = 1'b0;
            if (!bus.mis_pred_in) begin
                vld_d = '0;
                rr_d  = '0;
            end
        end

        if (wr_en) begin
            wr_idx          = upd ? upd_idx : rr_q;
            vld_d[wr_idx]   = 1'b1;
            start_d[wr_idx] = start_eff;
            tail_d[wr_idx]  = lp_tail_q;
            num_d[wr_idx]   = lp_num_d;
            if (!upd) rr_d = (rr_q == LAST) ? '0 : rr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vld_q      <= '0;
            rr_q       <= '0;
            lp_tail_q  <= '0;
            tr_start_q <= '0;
            lp_num_q   <= '0;
            issued_q   <= '0;
            pend_q     <= 1'b0;
            fnsh_q     <= 1'b0;
            stll_q     <= 1'b0;
            for (int e = 0; e < ENTRIES; e++) begin
                start_q[e] <= '0;
                tail_q[e]  <= '0;
                num_q[e]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            rr_q       <= rr_d;
            lp_tail_q  <= lp_tail_d;
            tr_start_q <= tr_start_d;
            lp_num_q   <= lp_num_d;
            issued_q   <= issued_d;
            pend_q     <= pend_d;
            fnsh_q     <= fnsh_d;
            stll_q     <= stll_d;
            for (int e = 0; e < ENTRIES; e++) begin
                start_q[e] <= start_d[e];
                tail_q[e]  <= tail_d[e];
                num_q[e]   <= num_d[e];
            end
        end
    end

    assign bus.lbd_state_out  = state_q;
    assign bus.loop_strt_out  = (state_q == S_IDLE) && bus.fetch_valid_in && hit
                                && !bus.mis_pred_in && !bus.lat_flush_in;
    assign bus.inst_valid_out = mask;
    assign bus.fnsh_unrll_out = fnsh_q;
    assign bus.stll_ftch_out  = stll_q;
endmodule
